e203_exu_flush_arb: RTL

//  Arbitrates pipeline-flush requests from the branch-resolve unit (brchmis) and the

---
 rtl/e203_exu_flush_arb_pkg.sv | 18 +
 rtl/e203_exu_flush_perfcnt.sv | 56 +++++
 rtl/e203_exu_flush_arb.sv | 128 ++++++++++++
 3 files changed

// File: rtl/e203_exu_flush_arb_pkg.sv
// ---------------------------------------------------------------------------
// e203_exu_flush_arb_pkg
//   Shared definitions for the EXU flush arbiter: FSM state encoding and the
//   flush-source codes carried on pipe_flush_src.
// ---------------------------------------------------------------------------
package e203_exu_flush_arb_pkg;

  // Arbiter FSM: IDLE waits for a source, REQ holds one flush toward the IFU.
  typedef enum logic {
    FSM_IDLE = 1'b0,
    FSM_REQ  = 1'b1
  } flush_state_e;

  // Flush source codes (value presented on pipe_flush_src).
  localparam logic SRC_BRCHMIS = 1'b0;
  localparam logic SRC_EXCPIRQ = 1'b1;

endpackage

// File: rtl/e203_exu_flush_perfcnt.sv
// ---------------------------------------------------------------------------
// e203_exu_flush_perfcnt
//   Flush performance counters: one per flush source. Only compiled when
//   E203_FLUSH_PERF_CNT_EN is defined.
// Ports:
//   clk, rst_n        clock, synchronous active-low reset
//   perf_clr          clear both counters (wins over a same-cycle increment)
//   brchmis_inc       +1 to the branch counter this cycle
//   excpirq_inc       +1 to the exception/IRQ counter this cycle
//   perf_brchmis_cnt  branch flush count (wraps modulo 2^CNT_W)
//   perf_excpirq_cnt  exception/IRQ flush count (wraps modulo 2^CNT_W)
// ---------------------------------------------------------------------------
`ifdef E203_FLUSH_PERF_CNT_EN
module e203_exu_flush_perfcnt #(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             perf_clr,
  input  logic             brchmis_inc,
  input  logic             excpirq_inc,
  output logic [CNT_W-1:0] perf_brchmis_cnt,
  output logic [CNT_W-1:0] perf_excpirq_cnt
);

  // Index 0 = brchmis, index 1 = excpirq.
  logic [1:0]       inc;
  logic [CNT_W-1:0] cnt_q [2];
  logic [CNT_W-1:0] cnt_d [2];

  assign inc = {excpirq_inc, brchmis_inc};

  for (genvar gi = 0; gi < 2; gi++) begin : g_cnt
    always_comb begin
      cnt_d[gi] = cnt_q[gi];
      if (perf_clr) begin
        cnt_d[gi] = '0;
      end else if (inc[gi]) begin
        cnt_d[gi] = cnt_q[gi] + CNT_W'(1);
      end
    end

    always_ff @(posedge clk) begin
      if (!rst_n) begin
        cnt_q[gi] <= '0;
      end else begin
        cnt_q[gi] <= cnt_d[gi];
      end
    end
  end

  assign perf_brchmis_cnt = cnt_q[0];
  assign perf_excpirq_cnt = cnt_q[1];

endmodule
`endif

// File: rtl/e203_exu_flush_arb.sv
// ---------------------------------------------------------------------------
// e203_exu_flush_arb
//   Commit-stage flush arbiter. Picks between the exception/IRQ unit (higher
//   priority) and the branch-resolve unit, computes the flush target
//   (op1+op2, bit 0 cleared) and holds one registered flush request to the
//   IFU until it is acknowledged. The grant is locked while in REQ.
// Optional feature: E203_FLUSH_PERF_CNT_EN adds per-source flush counters
//   (ports perf_clr, perf_brchmis_cnt, perf_excpirq_cnt).
// Ports:
//   clk, rst_n                 clock, synchronous active-low reset
//   brchmis_flush_req/op1/op2  branch flush request and target operands
//   brchmis_flush_ack          branch request accepted by IFU (combinational)
//   excpirq_flush_req/op1/op2  exception/IRQ flush request and target operands
//   excpirq_flush_ack          exception request accepted by IFU (combinational)
//   pipe_flush_req/pc/src      registered flush request to the IFU
//   pipe_flush_ack             IFU accepts the flush
//   flush_pending              arbiter busy or a request waiting; stall commit
// ---------------------------------------------------------------------------
module e203_exu_flush_arb #(
  parameter int PC_SIZE = 32
`ifdef E203_FLUSH_PERF_CNT_EN
  ,
  parameter int CNT_W   = 32
`endif
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               brchmis_flush_req,
  input  logic [PC_SIZE-1:0] brchmis_flush_add_op1,
  input  logic [PC_SIZE-1:0] brchmis_flush_add_op2,
  output logic               brchmis_flush_ack,
  input  logic               excpirq_flush_req,
  input  logic [PC_SIZE-1:0] excpirq_flush_add_op1,
  input  logic [PC_SIZE-1:0] excpirq_flush_add_op2,
  output logic               excpirq_flush_ack,
  output logic               pipe_flush_req,
  output logic [PC_SIZE-1:0] pipe_flush_pc,
  output logic               pipe_flush_src,
  input  logic               pipe_flush_ack,
`ifdef E203_FLUSH_PERF_CNT_EN
  input  logic               perf_clr,
  output logic [CNT_W-1:0]   perf_brchmis_cnt,
  output logic [CNT_W-1:0]   perf_excpirq_cnt,
`endif
  output logic               flush_pending
);

  import e203_exu_flush_arb_pkg::*;

  // Flush targets are halfword aligned: bit 0 is always cleared.
  localparam logic [PC_SIZE-1:0] PC_ALIGN_MASK = ~PC_SIZE'(1);

  flush_state_e       state_q, state_d;
  logic [PC_SIZE-1:0] pc_q, pc_d;
  logic               src_q, src_d;
  logic               grant_excp;
  logic [PC_SIZE-1:0] sel_op1, sel_op2;
  logic               in_req;

  // Operands are muxed before the add so one adder serves both sources.
  assign grant_excp = excpirq_flush_req;
  assign sel_op1    = grant_excp ? excpirq_flush_add_op1 : brchmis_flush_add_op1;
  assign sel_op2    = grant_excp ? excpirq_flush_add_op2 : brchmis_flush_add_op2;

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    src_d   = src_q;
    case (state_q)
      FSM_IDLE: begin
        if (excpirq_flush_req || brchmis_flush_req) begin
          state_d = FSM_REQ;
          src_d   = grant_excp ? SRC_EXCPIRQ : SRC_BRCHMIS;
          pc_d    = (sel_op1 + sel_op2) & PC_ALIGN_MASK;
        end
      end
      FSM_REQ: begin
        // Grant is locked here; a newly raised request waits for IDLE.
        if (pipe_flush_ack) begin
          state_d = FSM_IDLE;
        end
      end
      default: state_d = FSM_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= FSM_IDLE;
      pc_q    <= '0;
      src_q   <= SRC_BRCHMIS;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      src_q   <= src_d;
    end
  end

  assign in_req            = (state_q == FSM_REQ);
  assign pipe_flush_req    = in_req;
  assign pipe_flush_pc     = pc_q;
  assign pipe_flush_src    = src_q;
  assign brchmis_flush_ack = in_req && pipe_flush_ack && (src_q == SRC_BRCHMIS);
  assign excpirq_flush_ack = in_req && pipe_flush_ack && (src_q == SRC_EXCPIRQ);
  assign flush_pending     = in_req || excpirq_flush_req || brchmis_flush_req;

`ifdef E203_FLUSH_PERF_CNT_EN
  e203_exu_flush_perfcnt #(
    .CNT_W(CNT_W)
  ) u_perfcnt (
    .clk              (clk),
    .rst_n            (rst_n),
    .perf_clr         (perf_clr),
    .brchmis_inc      (brchmis_flush_ack),
    .excpirq_inc      (excpirq_flush_ack),
    .perf_brchmis_cnt (perf_brchmis_cnt),
    .perf_excpirq_cnt (perf_excpirq_cnt)
  );
`endif

  // A granted source must keep its request up until acknowledged; if it
  // drops early the latched flush still completes, but flag the violation.
  a_brchmis_held: assert property (@(posedge clk) disable iff (!rst_n)
    (in_req && src_q == SRC_BRCHMIS) |-> brchmis_flush_req);
  a_excpirq_held: assert property (@(posedge clk) disable iff (!rst_n)
    (in_req && src_q == SRC_EXCPIRQ) |-> excpirq_flush_req);

endmodule
